// File: rtl/spike_window_counter.sv
// Counts spikes from N_NEURON lines over windows of WINDOW_LEN enabled cycles and publishes a saturating count.
// Optional rising-edge-only spike counting is enabled with the SPIKE_EDGE_DETECT_EN macro.
module spike_window_counter #(
    parameter int N_NEURON   = 16,
    parameter int WINDOW_LEN = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N_NEURON-1:0] i_spikes,
    output logic [31:0]         o_spike_cnt,
    output logic                o_cnt_valid,
    output logic                o_overflow
);

    localparam int WIN_W = $clog2(WINDOW_LEN);
    localparam int POP_W = $clog2(N_NEURON + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [POP_W-1:0] popcount(input logic [N_NEURON-1:0] bits);
        logic [POP_W-1:0] n;
        n = {POP_W{1'b0}};
        for (int i = 0; i < N_NEURON; i++) begin
            n = n + POP_W'(bits[i]);
        end
        return n;
    endfunction

    logic [WIN_W-1:0]    win_cnt_r;
    logic [N_NEURON-1:0] cap_bits_s;
    logic [N_NEURON-1:0] s0_bits_r;
    logic                s0_v_r;
    logic                s0_last_r;
    logic [POP_W-1:0]    s1_pop_r;
    logic                s1_last_r;
    logic [CNT_W-1:0]    acc_r;
    logic                ovf_r;
    logic [CNT_W:0]      sum_wide_s;
    logic [CNT_W-1:0]    sum_s;
    logic                sat_s;
    logic [CNT_W-1:0]    s2_cnt_r;
    logic                s2_ovf_r;
    logic                s2_valid_r;

`ifdef SPIKE_EDGE_DETECT_EN
    logic [N_NEURON-1:0] prev_bits_r;

    // Remembers the previous enabled sample so held-high lines count once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_bits_r <= {N_NEURON{1'b0}};
        end else if (en) begin
            prev_bits_r <= i_spikes;
        end
    end

    assign cap_bits_s = i_spikes & ~prev_bits_r;
`else
    assign cap_bits_s = i_spikes;
`endif

    // Slot position within the current window; advances on enabled cycles only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_r <= {WIN_W{1'b0}};
        end else if (en) begin
            win_cnt_r <= (win_cnt_r == WIN_LAST) ? {WIN_W{1'b0}} : win_cnt_r + WIN_W'(1);
        end
    end

    // S0: input capture with valid and end-of-window tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_bits_r <= {N_NEURON{1'b0}};
            s0_v_r    <= 1'b0;
            s0_last_r <= 1'b0;
        end else begin
            s0_bits_r <= cap_bits_s;
            s0_v_r    <= en;
            s0_last_r <= en && (win_cnt_r == WIN_LAST);
        end
    end

    // S1: population count; disabled samples contribute nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_pop_r  <= {POP_W{1'b0}};
            s1_last_r <= 1'b0;
        end else begin
            s1_pop_r  <= s0_v_r ? popcount(s0_bits_r) : {POP_W{1'b0}};
            s1_last_r <= s0_last_r;
        end
    end

    // Saturating add of this sample's count into the window accumulator.
    always_comb begin
        sum_wide_s = {1'b0, acc_r} + (CNT_W + 1)'(s1_pop_r);
        sat_s      = (sum_wide_s > {1'b0, CNT_MAX});
        if (sat_s) begin
            sum_s = CNT_MAX;
        end else begin
            sum_s = sum_wide_s[CNT_W-1:0];
        end
    end

    // S2: accumulate, or hand the finished window to the output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r      <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            s2_cnt_r   <= {CNT_W{1'b0}};
            s2_ovf_r   <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (s1_last_r) begin
            s2_cnt_r   <= sum_s;
            s2_ovf_r   <= ovf_r | sat_s;
            s2_valid_r <= 1'b1;
            acc_r      <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            s2_valid_r <= 1'b0;
            acc_r      <= sum_s;
            ovf_r      <= ovf_r | sat_s;
        end
    end

    // Output registers: count and overflow only change together with the valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_spike_cnt <= 32'd0;
            o_overflow  <= 1'b0;
            o_cnt_valid <= 1'b0;
        end else begin
            o_cnt_valid <= s2_valid_r;
            if (s2_valid_r) begin
                o_spike_cnt <= 32'(s2_cnt_r);
                o_overflow  <= s2_ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_spike_window_counter.sv
// Randomized self-checking bench for spike_window_counter with a window-level reference model
// and directed checks pinned to hand-computed values.
module tb_spike_window_counter;
    localparam int N  = 64;
    localparam int WL = 8;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  spikes;
    logic [31:0]   cnt;
    logic          valid;
    logic          ovf;

    always #5 clk = ~clk;

    spike_window_counter #(.N_NEURON(N), .WINDOW_LEN(WL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .i_spikes(spikes),
        .o_spike_cnt(cnt), .o_cnt_valid(valid), .o_overflow(ovf)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    typedef struct { int due; int cnt; bit ovf; } pub_t;
    pub_t m_q[$];
    int m_slot = 0;
    int m_sum = 0;
    logic [N-1:0] m_prev = '0;
    bit exp_valid = 1'b0;
    int exp_cnt = 0;
    bit exp_ovf = 1'b0;

    int pub_cnt_q[$];
    bit pub_ovf_q[$];
    int pub_edge_q[$];

    function automatic int popc(input logic [N-1:0] b);
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(b[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-window sums, published 3 edges after the last sample edge.
    always @(posedge clk) begin
        pub_t p;
        cyc++;
        if (reset) begin
            m_slot = 0; m_sum = 0; m_prev = '0; m_q.delete();
            exp_valid = 1'b0; exp_cnt = 0; exp_ovf = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                exp_valid = 1'b1;
                exp_cnt = m_q[0].cnt;
                exp_ovf = m_q[0].ovf;
                void'(m_q.pop_front());
            end
            if (en) begin
`ifdef SPIKE_EDGE_DETECT_EN
                m_sum += popc(spikes & ~m_prev);
                m_prev = spikes;
`else
                m_sum += popc(spikes);
`endif
                m_slot++;
                if (m_slot == WL) begin
                    p.due = cyc + 3;
                    p.cnt = (m_sum > CMAX) ? CMAX : m_sum;
                    p.ovf = (m_sum > CMAX);
                    m_q.push_back(p);
                    m_slot = 0;
                    m_sum = 0;
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, valid}, {31'd0, exp_valid});
            chk("count", cnt, exp_cnt);
            chk("overflow", {31'd0, ovf}, {31'd0, exp_ovf});
            if (valid === 1'b1) begin
                pub_cnt_q.push_back(int'(cnt));
                pub_ovf_q.push_back(ovf);
                pub_edge_q.push_back(cyc);
            end
        end
    end

    task automatic step(input logic e, input logic [N-1:0] s);
        @(negedge clk);
        #1;
        en = e;
        spikes = s;
    endtask

    task automatic check_pubs(input string name, input int base, input int c0, input bit o0,
                              input int c1, input bit o1, input int gap);
        chk({name, "_npub"}, pub_cnt_q.size() - base, 2);
        if (pub_cnt_q.size() >= base + 2) begin
            chk({name, "_cnt0"}, pub_cnt_q[base], c0);
            chk({name, "_ovf0"}, {31'd0, pub_ovf_q[base]}, {31'd0, o0});
            chk({name, "_cnt1"}, pub_cnt_q[base+1], c1);
            chk({name, "_ovf1"}, {31'd0, pub_ovf_q[base+1]}, {31'd0, o1});
            chk({name, "_gap"}, pub_edge_q[base+1] - pub_edge_q[base], gap);
        end
    endtask

    initial begin
        int base;
        int start;
        int mode;
        logic [N-1:0] r;
        reset = 1'b1; en = 1'b0; spikes = '0;
        repeat (3) @(negedge clk);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk_en = 1'b1;
        #1 reset = 1'b0;

        // All lines firing for one window, then a silent window.
        base = pub_cnt_q.size();
        step(1'b1, {N{1'b1}});
        start = cyc;
        repeat (7) step(1'b1, {N{1'b1}});
        repeat (8) step(1'b1, '0);
        repeat (6) step(1'b0, '0);
`ifdef SPIKE_EDGE_DETECT_EN
        check_pubs("full", base, 64, 1'b0, 0, 1'b0, 8);
`else
        check_pubs("full", base, 255, 1'b1, 0, 1'b0, 8);
`endif
        if (pub_edge_q.size() > base) chk("full_latency", pub_edge_q[base] - start, 11);

        // Single spike in the last slot of a window belongs to that window.
        base = pub_cnt_q.size();
        for (int i = 0; i < 16; i++) step(1'b1, (i == 7) ? 64'd1 : 64'd0);
        repeat (6) step(1'b0, '0);
        check_pubs("boundary", base, 1, 1'b0, 0, 1'b0, 8);

        // Enable alternating 1,0 with one line constantly high.
        base = pub_cnt_q.size();
        for (int i = 0; i < 32; i++) step((i % 2) == 0, 64'd1);
        repeat (6) step(1'b0, '0);
`ifdef SPIKE_EDGE_DETECT_EN
        check_pubs("gating", base, 1, 1'b0, 0, 1'b0, 16);
`else
        check_pubs("gating", base, 8, 1'b0, 8, 1'b0, 16);
`endif

        // Reset in slot 5: outputs clear at once and the partial window is dropped.
        base = pub_cnt_q.size();
        repeat (5) step(1'b1, {$urandom, $urandom});
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_cnt", cnt, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        en = 1'b1; spikes = 64'd3;
        start = cyc;
        repeat (7) step(1'b1, 64'd3);
        repeat (6) step(1'b0, '0);
        chk("postrst_npub", pub_cnt_q.size() - base, 1);
        if (pub_cnt_q.size() > base) begin
`ifdef SPIKE_EDGE_DETECT_EN
            chk("postrst_cnt", pub_cnt_q[base], 2);
`else
            chk("postrst_cnt", pub_cnt_q[base], 16);
`endif
            chk("postrst_latency", pub_edge_q[base] - start, 11);
        end

        // Randomized traffic with varying density, enable gaps and occasional resets.
        mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 3);
            case (mode)
                0: r = {$urandom, $urandom};
                1: r = {$urandom, $urandom} | {$urandom, $urandom};
                2: r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                default: r = ($urandom_range(0, 1) == 1) ? {N{1'b1}} : '0;
            endcase
            step($urandom_range(0, 3) != 0, r);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) step(1'b1, r);
                reset = 1'b0;
            end
        end
        repeat (8) step(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spike_window_counter.md
# spike_window_counter

Counts spikes arriving from a population of N_NEURON spiking neurons over a fixed window of enabled clock cycles. Each completed window publishes an unsigned integer spike count on a 32-bit output. This block sits directly upstream of the floating-point recursive EMG filter and drives that filter's integer spike-count input. The count is held stable for a full window and flagged with a one-cycle valid pulse.

## Interface
- N_NEURON, 16: number of spike input lines; legal range 1..64.
- WINDOW_LEN, 1024: enabled cycles per counting window; must be ≥ 4.
- CNT_W, 32: accumulator width; legal range 8..32; the output is zero-extended to 32 bits.

- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  sample enable; cycles with en=0 are not part of any window.
- i_spikes  input  N_NEURON  one bit per neuron; 1 = neuron firing this cycle.
- o_spike_cnt  output  32  spike count of the last completed window; held between publishes.
- o_cnt_valid  output  1  one-cycle pulse coincident with each new o_spike_cnt value.
- o_overflow  output  1  1 = the accumulator saturated during the published window; updates with o_spike_cnt.

## Operation
- **Stage S0 (input register).** On each clk edge, capture i_spikes into s0_bits.
  - Capture the tag s0_v = en.
  - Capture s0_last = en && (win_cnt == WINDOW_LEN-1).
- **Window counter.** win_cnt counts 0..WINDOW_LEN-1.
  - It increments only when en=1.
  - It wraps to 0 after WINDOW_LEN-1.
  - When en=0 it holds its value.
- **Stage S1 (popcount).** Register s1_pop = popcount(s0_bits) when s0_v=1, otherwise 0.
  - s1_pop is ceil(log2(N_NEURON+1)) bits wide.
  - s0_last propagates to s1_last.
- **Stage S2 (accumulate/publish).** sum = acc + s1_pop, saturating at 2^CNT_W−1.
  - If saturation occurs, set the sticky flag ovf.
  - When s1_last=0: acc ← sum; ovf retains its sticky value.
  - When s1_last=1: o_spike_cnt ← zero-extended sum; o_overflow ← (ovf or saturation this cycle); o_cnt_valid ← 1; acc ← 0; ovf ← 0.
  - At all other times o_cnt_valid ← 0.
- **Window boundaries.** Boundaries are defined at S0. A spike sampled in the last enabled slot of a window belongs to that window. The next enabled sample belongs to the new window, even if en toggles.
- **en deassertion mid-pipeline.** The pipeline keeps draining. S0/S1 entries already captured are still accumulated.
- **Reset (asynchronous).**
  - Clears win_cnt, all pipeline registers, acc and ovf.
  - o_spike_cnt=0, o_cnt_valid=0, o_overflow=0.
  - A partial window in progress is discarded, with no publish. The first window after reset starts at the first enabled cycle.

## Timing
- Latency: o_cnt_valid is high in the cycle immediately after the clk edge that is 3 edges after the edge sampling the window's last slot. Between those two points, the edge at +1 registers S1 and the edge at +2 registers S2.
- Throughput: one sample per clk; no stalls; no back-pressure.
- With en tied high, o_cnt_valid has period exactly WINDOW_LEN cycles.
- o_spike_cnt changes only on edges where o_cnt_valid rises. It is stable for at least WINDOW_LEN−1 cycles, so the downstream filter may sample it on any later clock.
- Reset deasserted mid-window behaves as a fresh power-on.

## Configuration
- SPIKE_EDGE_DETECT_EN defined:
  - S0 adds a register prev_bits, reset 0, updated only when en=1.
  - The captured value becomes i_spikes & ~prev_bits, so a neuron holding its line high for k enabled cycles counts once.
- SPIKE_EDGE_DETECT_EN undefined:
  - Every enabled cycle with a bit high counts as one spike.
  - prev_bits is not instantiated.

## Test plan
- **Full-rate count.** N_NEURON=16, WINDOW_LEN=8, en=1, i_spikes=16'hFFFF, macro undefined -> o_spike_cnt=128 and o_cnt_valid pulse every 8 cycles; first pulse 3 cycles after the 8th sample edge.
- **Edge detection.** Same stimulus with SPIKE_EDGE_DETECT_EN defined -> first window 16, every later window 0; toggling all bits 0/1 each cycle gives 64.
- **Boundary attribution.** WINDOW_LEN=8, single bit high only in slot 7 of window 0 -> window 0 publishes 1, window 1 publishes 0.
- **Enable gating.** WINDOW_LEN=8, i_spikes=1 bit high constantly, en pattern 1,0 repeated -> each publish = 8, period 16 cycles, no extra counts from en=0 cycles.
- **Saturation.** CNT_W=8, N_NEURON=64, WINDOW_LEN=8, all ones -> o_spike_cnt=255, o_overflow=1; next window with i_spikes=0 -> 0, o_overflow=0.
- **Reset mid-window.** Assert reset at slot 5 -> outputs 0 immediately; after release, next publish reflects only post-reset samples, WINDOW_LEN enabled cycles later.
